// File: rtl/lsu_sequencer.sv
// Load/store sequencer between execute and the data memory port.
// Decodes the ROM/RAM region, walks vector lanes one at a time, and assembles load results.
module lsu_lane #(
  parameter int S = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         cap,
  input  logic [S-1:0] d,
  output logic [S-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (cap) q <= d;
endmodule

module lsu_sequencer #(
  parameter int S           = 32,
  parameter int V           = 192,
  parameter int ROM_BASE    = 1000,
  parameter int RAM_BASE    = 151000,
  parameter int REGION_SIZE = 150000,
  parameter int MEM_LAT     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic         req_vec,
  input  logic [S-1:0] req_addr,
  input  logic [V-1:0] req_wd,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [V-1:0] resp_rd,
  output logic         resp_fault,
  output logic         mem_sel,
  output logic [S-1:0] mem_addr,
  output logic         mem_we,
  output logic [S-1:0] mem_wd,
  input  logic [S-1:0] mem_rd
);
  localparam int LANES = V / S;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  // Region bounds carry one extra bit so last-lane overflow lands outside every region.
  localparam logic [S:0] ROM_LO = (S+1)'(ROM_BASE);
  localparam logic [S:0] ROM_HI = (S+1)'(ROM_BASE + REGION_SIZE);
  localparam logic [S:0] RAM_LO = (S+1)'(RAM_BASE);
  localparam logic [S:0] RAM_HI = (S+1)'(RAM_BASE + REGION_SIZE);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                    we;
    logic                    vec;
    logic [LANES-1:0][S-1:0] wd;
  } req_t;

  state_t                  state;
  req_t                    r;
  logic [LW-1:0]           lane, n_last;
  logic [CW-1:0]           cnt;
  logic [LANES-1:0][S-1:0] rd_buf;
  logic                    accept, sample, lane_done;

  logic [S:0]   first_x, last_x;
  logic         in_rom, in_ram, dec_fault;
  logic [S-1:0] dec_off;

  always_comb begin
    first_x   = {1'b0, req_addr};
    last_x    = first_x + (req_vec ? (S+1)'(LANES-1) : '0);
    in_rom    = (first_x >= ROM_LO) && (last_x < ROM_HI);
    in_ram    = (first_x >= RAM_LO) && (last_x < RAM_HI);
    // A straddling vector matches neither region; stores are legal only in RAM.
    dec_fault = !(in_rom || in_ram) || (req_we && !in_ram);
    dec_off   = in_ram ? req_addr - S'(RAM_BASE) : req_addr - S'(ROM_BASE);
  end

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = (state == IDLE) && req_valid;
  assign lane_done = (cnt == CW'(MEM_LAT-1));
  assign sample    = (state == ACCESS) && !r.we && lane_done;
  assign n_last    = r.vec ? LW'(LANES-1) : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lsu_lane #(.S(S)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (accept),
      .cap   (sample && (lane == LW'(i))),
      .d     (mem_rd),
      .q     (rd_buf[i])
    );
  end

  assign resp_rd = rd_buf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      r          <= '0;
      lane       <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      mem_sel    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wd     <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r.we       <= req_we;
          r.vec      <= req_vec;
          r.wd       <= req_wd;
          lane       <= '0;
          cnt        <= '0;
          resp_fault <= dec_fault;
          if (dec_fault) begin
            state <= RESP;
          end else begin
            // Lane 0 goes out on the accept edge so memory sees it the very next cycle.
            state    <= ACCESS;
            mem_sel  <= in_ram;
            mem_addr <= dec_off;
            mem_we   <= req_we;
            mem_wd   <= req_wd[S-1:0];
          end
        end
        ACCESS: begin
          if (lane_done) begin
            cnt <= '0;
            if (lane == n_last) begin
              state    <= RESP;
              mem_sel  <= 1'b0;
              mem_addr <= '0;
              mem_we   <= 1'b0;
              mem_wd   <= '0;
            end else begin
              lane     <= lane + 1'b1;
              mem_addr <= mem_addr + 1'b1;
              mem_we   <= r.we;
              mem_wd   <= r.wd[lane + 1'b1];
            end
          end else begin
            cnt    <= cnt + 1'b1;
            mem_we <= 1'b0;
          end
        end
        RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: RAM array model, functional ROM, write log.
module tb_lsu_sequencer;
  localparam int S = 32;
  localparam int V = 192;
  localparam int LANES = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0, req_we = 1'b0, req_vec = 1'b0;
  logic [S-1:0] req_addr = '0;
  logic [V-1:0] req_wd = '0;
  logic         resp_ready = 1'b0;
  logic         req_ready, resp_valid, resp_fault, mem_sel, mem_we;
  logic [V-1:0] resp_rd;
  logic [S-1:0] mem_addr, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  logic [S-1:0] ram [64];
  logic [64:0]  wr_log [$];

  lsu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_vec(req_vec),
    .req_addr(req_addr), .req_wd(req_wd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd), .resp_fault(resp_fault),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem_sel ? ((mem_addr < 64) ? ram[mem_addr[5:0]] : 32'h0)
                          : (32'hA500_0000 + mem_addr);

  always @(posedge clk) begin
    if (mem_we) begin
      wr_log.push_back({mem_sel, mem_addr, mem_wd});
      if (mem_sel && mem_addr < 64) ram[mem_addr[5:0]] = mem_wd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic we, input logic vec, input logic [S-1:0] addr,
                        input logic [V-1:0] wd, output int lat);
    @(negedge clk);
    wr_log.delete();
    req_we = we; req_vec = vec; req_addr = addr; req_wd = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    checks++; if (mem_we !== 1'b0 || mem_sel !== 1'b0) begin errors++; $display("FAIL rst_mem_we_sel got %b%b exp 00", mem_we, mem_sel); end
    checks++; if (mem_addr !== '0 || mem_wd !== '0) begin errors++; $display("FAIL rst_mem_addr_wd got %h %h exp 0 0", mem_addr, mem_wd); end
    checks++; if (resp_rd !== '0 || resp_fault !== 1'b0) begin errors++; $display("FAIL rst_resp got %h %b exp 0 0", resp_rd, resp_fault); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    resp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL idle_resp_ready got %b%b exp 01", resp_valid, req_ready); end
  endtask

  task automatic test_scalar_load();
    int lat;
    do_req(1'b0, 1'b0, 32'd151005, '0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sload_lat got %0d exp 2", lat); end
    checks++; if (resp_rd !== {160'h0, 32'hDEADBEEF}) begin errors++; $display("FAIL sload_rd got %h exp deadbeef", resp_rd); end
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL sload_fault got %b exp 0", resp_fault); end
    finish_resp();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL sload_done got %b%b exp 01", resp_valid, req_ready); end
  endtask

  task automatic test_vec_store();
    int lat;
    logic [V-1:0] wd;
    logic [64:0]  exp_e;
    for (int i = 0; i < LANES; i++) wd[i*S +: S] = 32'(i + 1);
    do_req(1'b1, 1'b1, 32'd151010, wd, lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL vstore_lat got %0d exp 7", lat); end
    checks++; if (resp_fault !== 1'b0 || resp_rd !== '0) begin errors++; $display("FAIL vstore_resp got %b %h exp 0 0", resp_fault, resp_rd); end
    checks++; if (wr_log.size() !== LANES) begin errors++; $display("FAIL vstore_pulses got %0d exp 6", wr_log.size()); end
    for (int i = 0; i < LANES && i < wr_log.size(); i++) begin
      exp_e = {1'b1, 32'(10 + i), 32'(i + 1)};
      checks++; if (wr_log[i] !== exp_e) begin errors++; $display("FAIL vstore_lane%0d got %h exp %h", i, wr_log[i], exp_e); end
    end
    finish_resp();
  endtask

  task automatic test_vec_load(input logic [S-1:0] addr, input logic [S-1:0] off0, input string nm);
    int lat;
    logic [V-1:0] exp_rd;
    for (int i = 0; i < LANES; i++) exp_rd[i*S +: S] = 32'hA500_0000 + off0 + 32'(i);
    do_req(1'b0, 1'b1, addr, '0, lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL %s_lat got %0d exp 7", nm, lat); end
    checks++; if (resp_rd !== exp_rd) begin errors++; $display("FAIL %s_rd got %h exp %h", nm, resp_rd, exp_rd); end
    checks++; if (resp_fault !== 1'b0 || wr_log.size() !== 0) begin errors++; $display("FAIL %s_fault_we got %b %0d exp 0 0", nm, resp_fault, wr_log.size()); end
    finish_resp();
  endtask

  task automatic test_faults();
    logic         f_we  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         f_vec [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [S-1:0] f_adr [5] = '{32'd1000, 32'd500, 32'd150998, 32'd301000, 32'hFFFF_FFFC};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_req(f_we[i], f_vec[i], f_adr[i], {V{1'b1}}, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL fault%0d_lat got %0d exp 1", i, lat); end
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL fault%0d_flag got %b exp 1", i, resp_fault); end
      checks++; if (resp_rd !== '0 || wr_log.size() !== 0) begin errors++; $display("FAIL fault%0d_rd_we got %h %0d exp 0 0", i, resp_rd, wr_log.size()); end
      finish_resp();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_req(1'b0, 1'b0, 32'd151005, '0, lat);
    req_we = 1'b0; req_vec = 1'b0; req_addr = 32'd1003; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rd !== {160'h0, 32'hDEADBEEF}) begin
        errors++; $display("FAIL bp_hold%0d got v=%b rdy=%b rd=%h exp 1 0 deadbeef", c, resp_valid, req_ready, resp_rd);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake got %b%b exp 01", resp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_reaccept got %b exp 0", req_ready); end
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 2 || resp_rd !== {160'h0, 32'hA500_0003}) begin errors++; $display("FAIL bp_second got %0d %h exp 2 a5000003", lat, resp_rd); end
    finish_resp();
  endtask

  task automatic test_reset_mid();
    logic [V-1:0] wd;
    logic [S-1:0] exp_w;
    for (int i = 0; i < LANES; i++) begin
      ram[20 + i] = 32'h5555_0000 + 32'(i);
      wd[i*S +: S] = 32'hC0DE_0000 + 32'(i);
    end
    @(negedge clk);
    req_we = 1'b1; req_vec = 1'b1; req_addr = 32'd151020; req_wd = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd23 || mem_wd !== 32'hC0DE_0003) begin
      errors++; $display("FAIL mid_lane3 got %b %0d %h exp 1 23 c0de0003", mem_we, mem_addr, mem_wd);
    end
    reset = 1'b1; #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL mid_we_drop got %b %0d exp 0 0", mem_we, mem_addr); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0; #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL mid_release got %b%b exp 10", req_ready, resp_valid); end
    for (int i = 0; i < LANES; i++) begin
      exp_w = (i < 3) ? 32'hC0DE_0000 + 32'(i) : 32'h5555_0000 + 32'(i);
      checks++; if (ram[20 + i] !== exp_w) begin errors++; $display("FAIL mid_ram%0d got %h exp %h", i, ram[20 + i], exp_w); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = '0;
    ram[5] = 32'hDEADBEEF;
    test_reset();
    test_scalar_load();
    test_vec_store();
    test_vec_load(32'd1000, 32'd0, "vload_rom");
    test_faults();
    test_vec_load(32'd150994, 32'd149994, "vload_rom_top");
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
